zeroriscy_data_slave: RTL and testbench

- Synthesizable responder for the core's LSU data interface (req/gnt/rvalid), the memory-side end of that protocol.
- Backs a word-addressed on-chip RAM with byte-enable writes.
- Returns read data or an error response after a fixed, parameterized latency.
- Sits between the core's data port and the TB/FPGA memory map. Its error responses drive the core's LSU-error exception path (EXC_OFF_LSUERR).

---
 rtl/zeroriscy_data_slave_pkg.sv | 21 ++
 rtl/zeroriscy_lfsr16.sv | 22 ++
 rtl/zeroriscy_data_slave.sv | 141 ++++++++++++++
 tb/tb_zeroriscy_data_slave.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_data_slave_pkg.sv
// Shared types and constants for the LSU data-side memory responder.
// Package zeroriscy_defines: response stage struct and stall-generator constants.
package zeroriscy_defines;

   // One response pipeline stage: valid flag, error flag and read data.
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } data_resp_t;

   // Reset seed of the stall LFSR.
   localparam logic [15:0] DATA_SLAVE_LFSR_SEED = 16'hACE1;

   // After this many consecutive stalled request cycles the grant is forced.
   localparam logic [2:0]  DATA_SLAVE_MAX_STALL = 3'd3;

   // Right-shift Galois feedback mask for x^16 + x^15 + x^13 + x^4 + 1.
   localparam logic [15:0] DATA_SLAVE_LFSR_TAPS = 16'hD008;

endpackage

// File: rtl/zeroriscy_lfsr16.sv
// 16-bit Galois LFSR used as the pseudo-random stall source of the data slave.
// Loads 'seed' on reset and advances one step per cycle while 'en' is high.
module zeroriscy_lfsr16
   import zeroriscy_defines::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   // Shift right, folding the outgoing bit back through the tap mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= seed;
      end else if (en) begin
         value <= {1'b0, value[15:1]} ^ (value[0] ? DATA_SLAVE_LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/zeroriscy_data_slave.sv
// Memory-side responder for the core's LSU data interface (req/gnt/rvalid).
// Word-addressed RAM with byte-enable writes; read data or an error response
// is returned RESP_LATENCY cycles after the grant edge, in order, with no
// backpressure. Out-of-range accesses return err=1 and never touch the RAM.
//
// Handshake: data_gnt_o is combinational on data_req_i; a transaction is
// accepted on every rising edge where req and gnt are both high. Exactly one
// data_rvalid_o pulse follows each accepted transaction; rdata/err are zero
// whenever rvalid is low.
//
// Optional macro ZERORISCY_DATA_SLAVE_STALL_EN: pseudo-random grant stalls
// (about 25% of cycles) bounded to three consecutive stalled request cycles.
module zeroriscy_data_slave
   import zeroriscy_defines::*;
#(
   parameter int          ADDR_WIDTH   = 32,
   parameter int          MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          RESP_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  data_err_o
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic                  stall;
   logic [ADDR_WIDTH-1:0] offset;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [31:0]           mem [MEM_WORDS];
   data_resp_t            resp_d;
   data_resp_t            resp_q [RESP_LATENCY];

`ifdef ZERORISCY_DATA_SLAVE_STALL_EN
   logic [15:0] lfsr_value;
   logic [2:0]  stall_cnt;
   logic        unused_lfsr_bits;

   zeroriscy_lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .seed  (DATA_SLAVE_LFSR_SEED),
      .value (lfsr_value)
   );

   assign unused_lfsr_bits = ^lfsr_value[15:2];
   assign stall = (lfsr_value[1:0] == 2'b00) && (stall_cnt < DATA_SLAVE_MAX_STALL);

   // Count consecutive stalled request cycles; any grant or idle cycle clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 3'd0;
      end else if (data_req_i && stall) begin
         stall_cnt <= stall_cnt + 3'd1;
      end else begin
         stall_cnt <= 3'd0;
      end
   end
`else
   assign stall = 1'b0;
`endif

   assign data_gnt_o = data_req_i & ~stall;

   // Decode: byte offset from the base; the wrap on addresses below the base
   // lands far above the RAM, so a single compare covers both range limits.
   assign offset   = data_addr_i - ADDR_WIDTH'(BASE_ADDR);
   assign in_range = (data_addr_i >= ADDR_WIDTH'(BASE_ADDR)) &&
                     ((offset >> 2) < ADDR_WIDTH'(MEM_WORDS));
   assign idx      = offset[IDX_W+1:2];

   // Byte-enable write at the grant edge; RAM contents are never reset.
   always_ff @(posedge clk) begin
      if (data_gnt_o && data_we_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Build the response for this cycle's grant; all-zero when nothing is granted.
   always_comb begin
      resp_d       = '0;
      resp_d.valid = data_gnt_o;
      resp_d.err   = data_gnt_o & ~in_range;
      if (data_gnt_o && in_range && !data_we_i) begin
         resp_d.rdata = mem[idx];
      end
   end

   // Fixed-latency response shift register; reset discards in-flight responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RESP_LATENCY; i++) begin
            resp_q[i] <= '0;
         end
      end else begin
         resp_q[0] <= resp_d;
         for (int i = 1; i < RESP_LATENCY; i++) begin
            resp_q[i] <= resp_q[i-1];
         end
      end
   end

   assign data_rvalid_o = resp_q[RESP_LATENCY-1].valid;
   assign data_err_o    = resp_q[RESP_LATENCY-1].err;
   assign data_rdata_o  = resp_q[RESP_LATENCY-1].rdata;

`ifndef SYNTHESIS
   logic [3:0] outstanding;

   // Track grants not yet answered so every rvalid can be tied to one grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= 4'd0;
      end else begin
         outstanding <= outstanding + {3'b000, data_gnt_o} - {3'b000, data_rvalid_o};
      end
   end

   a_latency_range : assert property (@(posedge clk)
      (RESP_LATENCY >= 1) && (RESP_LATENCY <= 4));

   a_rvalid_has_grant : assert property (@(posedge clk) disable iff (!rst_n)
      data_rvalid_o |-> (outstanding != 4'd0));
`endif

endmodule

// File: tb/tb_zeroriscy_data_slave.sv
// Self-checking bench for zeroriscy_data_slave (RESP_LATENCY = 3).
// A behavioural memory model predicts each response and the cycle it is due;
// a negedge monitor compares every rvalid against the expected queue.
module tb_zeroriscy_data_slave;

   localparam int          LAT       = 3;
   localparam int          MEM_WORDS = 1024;
   localparam logic [31:0] BASE      = 32'h0000_0000;
   localparam int          EW        = 65;   // {due[31:0], err, rdata[31:0]}

   logic        clk;
   logic        rst_n;
   logic        data_req;
   logic        data_gnt;
   logic [31:0] data_addr;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_wdata;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_err;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int rvalid_cnt = 0;

   logic [EW-1:0] exp_q[$];
   logic [31:0]   mm [MEM_WORDS];

   zeroriscy_data_slave #(
      .ADDR_WIDTH   (32),
      .MEM_WORDS    (MEM_WORDS),
      .BASE_ADDR    (BASE),
      .RESP_LATENCY (LAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_req_i    (data_req),
      .data_gnt_o    (data_gnt),
      .data_addr_i   (data_addr),
      .data_we_i     (data_we),
      .data_be_i     (data_be),
      .data_wdata_i  (data_wdata),
      .data_rvalid_o (data_rvalid),
      .data_rdata_o  (data_rdata),
      .data_err_o    (data_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Applies the transaction to the model memory and queues the expected response.
   function automatic void model_push(input logic we, input logic [31:0] addr,
                                      input logic [3:0] be, input logic [31:0] wd,
                                      input int due);
      longint     off;
      bit         ok;
      int         word;
      logic [31:0] rd;
      off  = {32'b0, addr} - {32'b0, BASE};
      ok   = (off >= 0) && (off < longint'(MEM_WORDS) * 4);
      word = ok ? int'(off / 4) : 0;
      rd   = 32'h0;
      if (ok && we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mm[word][8*b +: 8] = wd[8*b +: 8];
      end else if (ok) begin
         rd = mm[word];
      end
      exp_q.push_back({due[31:0], ~ok, rd});
   endfunction

   // ---------------- driver tasks ----------------
   // Present one request and hold it until granted (bounded).
   task automatic issue(input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      bit done;
      int tries;
      done  = 0;
      tries = 0;
      data_req   = 1'b1;
      data_we    = we;
      data_addr  = addr;
      data_be    = be;
      data_wdata = wd;
      while (!done && tries < 8) begin
         @(negedge clk);
         tries++;
         if (data_gnt === 1'b1) begin
            done = 1;
            model_push(we, addr, be, wd, edge_cnt + LAT);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL grant_timeout addr=%h observed no gnt required gnt within 8 cycles", addr);
      end
`ifndef ZERORISCY_DATA_SLAVE_STALL_EN
      checks++;
      assert (tries == 1) else begin
         errors++;
         $error("FAIL gnt_same_cycle addr=%h observed tries=%0d required 1", addr, tries);
      end
`endif
   endtask

   // Drop the request for n cycles, wiggling the unqualified inputs.
   task automatic idle(input int n);
      data_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         data_addr  = $urandom;
         data_we    = 1'($urandom_range(0, 1));
         data_be    = 4'($urandom_range(0, 15));
         data_wdata = $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain;
      idle(LAT + 2);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL drain observed %0d pending responses required 0", exp_q.size());
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n !== 1'b1) begin
         checks++;
         assert ({data_rvalid, data_err, data_rdata} === 34'b0) else begin
            errors++;
            $error("FAIL reset_outputs observed rvalid=%b err=%b rdata=%h required all 0",
                   data_rvalid, data_err, data_rdata);
         end
      end else if (data_rvalid === 1'b1) begin
         rvalid_cnt++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_rvalid cycle=%0d observed rvalid=1 required no response", edge_cnt);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (int'(e[64:33]) == edge_cnt) else begin
               errors++;
               $error("FAIL resp_latency observed cycle=%0d required cycle=%0d", edge_cnt, int'(e[64:33]));
            end
            checks++;
            assert ({data_err, data_rdata} === e[32:0]) else begin
               errors++;
               $error("FAIL resp_data observed err=%b rdata=%h required err=%b rdata=%h",
                      data_err, data_rdata, e[32], e[31:0]);
            end
         end
      end else begin
         checks++;
         assert (data_rvalid === 1'b0 && data_err === 1'b0 && data_rdata === 32'b0) else begin
            errors++;
            $error("FAIL idle_hygiene observed rvalid=%b err=%b rdata=%h required 0/0/0",
                   data_rvalid, data_err, data_rdata);
         end
         if (exp_q.size() != 0) begin
            checks++;
            assert (int'(exp_q[0][64:33]) > edge_cnt) else begin
               errors++;
               $error("FAIL missing_rvalid cycle=%0d observed rvalid=0 required rvalid=1", edge_cnt);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int gnt_cnt;
      int rv_start;
      int run0;
      int max_run;
      rst_n      = 1'b0;
      data_req   = 1'b0;
      data_addr  = 32'h0;
      data_we    = 1'b0;
      data_be    = 4'h0;
      data_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      assert (data_gnt === 1'b0) else begin
         errors++;
         $error("FAIL reset_gnt observed %b required 0", data_gnt);
      end
      rst_n = 1'b1;
      idle(2);

      // Preload the words the random phase reads, plus the last in-range word.
      for (int i = 0; i < 32; i++) issue(1'b1, i * 4, 4'hF, $urandom);
      issue(1'b1, 32'h0000_0FFC, 4'hF, 32'hC0FF_EE01);
      drain();

      // Full write then read-after-write of the same word.
      issue(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      drain();

      // Partial byte write then read back.
      issue(1'b1, 32'h10, 4'b0010, 32'h0000_AA00);
      idle(1);
      issue(1'b0, 32'h10, 4'hF, 32'h0);
      drain();

      // Out-of-range read and write; word 0 must be untouched.
      issue(1'b0, 32'h0000_1000, 4'hF, 32'h0);
      issue(1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678);
      issue(1'b0, 32'h0, 4'hF, 32'h0);
      issue(1'b0, 32'h0000_0FFC, 4'hF, 32'h0);
      issue(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0);
      drain();

      // be=0000 write is a no-op; low address bits are ignored.
      issue(1'b1, 32'h4, 4'b0000, 32'hFFFF_FFFF);
      issue(1'b0, 32'h7, 4'b0001, 32'h0);
      drain();

      // Eight back-to-back reads.
      for (int i = 0; i < 8; i++) issue(1'b0, i * 4, 4'hF, 32'h0);
      drain();

      // Reset with two reads in flight: both responses are discarded.
      issue(1'b0, 32'h8, 4'hF, 32'h0);
      issue(1'b0, 32'hC, 4'hF, 32'h0);
      data_req = 1'b0;
      rst_n    = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      assert (data_rvalid === 1'b0) else begin
         errors++;
         $error("FAIL async_reset_rvalid observed %b required 0", data_rvalid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(LAT + 3);
      issue(1'b0, 32'h8, 4'hF, 32'h0);
      drain();

      // Randomized mix of reads, writes and error accesses with idle gaps.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0:       a = 32'h1000 + 32'($urandom_range(0, 4000)) * 4 + 32'($urandom_range(0, 3));
            default: a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
         endcase
         issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      drain();

`ifdef ZERORISCY_DATA_SLAVE_STALL_EN
      // Hold req for 200 cycles: bounded stall runs and one rvalid per grant.
      gnt_cnt  = 0;
      rv_start = rvalid_cnt;
      run0     = 0;
      max_run  = 0;
      data_req = 1'b1;
      data_we  = 1'b0;
      data_be  = 4'hF;
      for (int c = 0; c < 200; c++) begin
         data_addr = 32'($urandom_range(0, 31)) * 4;
         @(negedge clk);
         if (data_gnt === 1'b1) begin
            gnt_cnt++;
            run0 = 0;
            model_push(1'b0, data_addr, 4'hF, 32'h0, edge_cnt + LAT);
         end else begin
            run0++;
            if (run0 > max_run) max_run = run0;
         end
         @(posedge clk);
         #1;
      end
      drain();
      checks++;
      assert (max_run <= 3) else begin
         errors++;
         $error("FAIL stall_run observed %0d consecutive stalls required <= 3", max_run);
      end
      checks++;
      assert (rvalid_cnt - rv_start == gnt_cnt) else begin
         errors++;
         $error("FAIL rvalid_count observed %0d required %0d", rvalid_cnt - rv_start, gnt_cnt);
      end
`else
      gnt_cnt  = 0;
      rv_start = 0;
      run0     = 0;
      max_run  = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
